// File: rtl/fpga_template_pkg.sv
// Shared types and default geometry for the I2S receiver.
package fpga_template_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;
    localparam int DEFAULT_SLOT_WIDTH   = 32;

endpackage

// File: rtl/i2s_edge_detect.sv
// SCK edge detector; with I2S_RX_INPUT_SYNC_EN defined, sck/ws/sd first pass
// through 2-flop synchronizers (2 extra clk cycles of latency).
module i2s_edge_detect #(
    parameter logic WS_POL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic ws_o,
    output logic sd_o
);

    logic sck_s;
    logic sck_prev_q;

`ifdef I2S_RX_INPUT_SYNC_EN
    logic [1:0] sck_sync_q;
    logic [1:0] ws_sync_q;
    logic [1:0] sd_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q <= 2'b00;
            ws_sync_q  <= {WS_POL, WS_POL};
            sd_sync_q  <= 2'b00;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_i};
            ws_sync_q  <= {ws_sync_q[0], ws_i};
            sd_sync_q  <= {sd_sync_q[0], sd_i};
        end
    end

    assign sck_s = sck_sync_q[1];
    assign ws_o  = ws_sync_q[1];
    assign sd_o  = sd_sync_q[1];
`else
    assign sck_s = sck_i;
    assign ws_o  = ws_i;
    assign sd_o  = sd_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_prev_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
        end
    end

    assign sck_rise_o = ~sck_prev_q & sck_s;
    assign sck_fall_o = sck_prev_q & ~sck_s;

endmodule

// File: rtl/i2s_rx.sv
// I2S stereo receiver with a valid/ready pair output, sticky overflow and
// short-slot error pulse. Optional input synchronizers: I2S_RX_INPUT_SYNC_EN.
module i2s_rx
    import fpga_template_pkg::*;
#(
    parameter int   SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int   SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
    parameter logic WS_POL       = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sck_i,
    input  logic                    ws_i,
    input  logic                    sd_i,
    output logic [SAMPLE_WIDTH-1:0] left_o,
    output logic [SAMPLE_WIDTH-1:0] right_o,
    output logic                    pair_valid_o,
    input  logic                    pair_ready_i,
    output logic                    overflow_o,
    output logic                    frame_err_o
);

    localparam int            CW       = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] SLOT_MAX = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH);

    logic sck_rise;
    logic unused_sck_fall;
    logic ws_s;
    logic sd_s;

    i2s_edge_detect #(.WS_POL(WS_POL)) u_edge (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (sck_i),
        .ws_i       (ws_i),
        .sd_i       (sd_i),
        .sck_rise_o (sck_rise),
        .sck_fall_o (unused_sck_fall),
        .ws_o       (ws_s),
        .sd_o       (sd_s)
    );

    rx_state_e               state_q, state_d;
    logic                    ws_prev_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           idx;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [SAMPLE_WIDTH-1:0] left_hold_q;
    logic [SAMPLE_WIDTH-1:0] word_next;
    logic                    left_ok_q;
    logic                    ws_edge;
    logic                    capture;
    logic                    left_done;
    logic                    pair_done;
    logic                    short_slot;

    assign ws_edge   = sck_rise && (ws_s != ws_prev_q);
    // cnt_q holds the index of the last rise in the slot; idx is this rise.
    assign idx       = (cnt_q == SLOT_MAX) ? SLOT_MAX : cnt_q + CW'(1);
    assign word_next = {shift_q[SAMPLE_WIDTH-2:0], sd_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        left_done  = 1'b0;
        pair_done  = 1'b0;
        short_slot = 1'b0;
        if (ws_edge) begin
            if (state_q != ST_IDLE && cnt_q < LAST_BIT) begin
                short_slot = 1'b1;
            end
            if (ws_s == WS_POL) begin
                state_d = ST_LEFT;
            end else if (state_q != ST_IDLE) begin
                state_d = ST_RIGHT;
            end
        end else if (sck_rise && state_q != ST_IDLE && idx <= LAST_BIT) begin
            capture = 1'b1;
            if (idx == LAST_BIT) begin
                left_done = (state_q == ST_LEFT);
                pair_done = (state_q == ST_RIGHT) && left_ok_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ws_prev_q    <= WS_POL;
            cnt_q        <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_ok_q    <= 1'b0;
            left_o       <= '0;
            right_o      <= '0;
            pair_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            frame_err_o <= short_slot;
            if (sck_rise) begin
                ws_prev_q <= ws_s;
                if (ws_edge) begin
                    cnt_q   <= '0;
                    shift_q <= '0;
                end else begin
                    cnt_q <= idx;
                end
            end
            // A fresh left slot invalidates any previously held left word.
            if (ws_edge && ws_s == WS_POL) begin
                left_ok_q <= 1'b0;
            end
            if (capture) begin
                shift_q <= word_next;
            end
            if (left_done) begin
                left_hold_q <= word_next;
                left_ok_q   <= 1'b1;
            end
            if (pair_done) begin
                if (!pair_valid_o || pair_ready_i) begin
                    left_o       <= left_hold_q;
                    right_o      <= word_next;
                    pair_valid_o <= 1'b1;
                end else begin
                    overflow_o <= 1'b1;
                end
            end else if (pair_valid_o && pair_ready_i) begin
                pair_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed testbench for i2s_rx: an I2S source at 8 clk per SCK, 32-bit slots.
module tb_i2s_rx;

    localparam int SW   = 24;
    localparam int SLOT = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sck_i = 1'b0;
    logic          ws_i  = 1'b1;
    logic          sd_i  = 1'b0;
    logic [SW-1:0] left_o;
    logic [SW-1:0] right_o;
    logic          pair_valid_o;
    logic          pair_ready_i = 1'b1;
    logic          overflow_o;
    logic          frame_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_set_cyc = 0;
    int mark_cyc = 0;
    int valid_start_cyc = -1;
    int valid_hi_cnt = 0;
    int xfer_cnt = 0;
    int ferr_cnt = 0;
    logic [SW-1:0] last_l = '0;
    logic [SW-1:0] last_r = '0;
    logic v_prev = 1'b0;
    int base_x, base_v, base_f;

    i2s_rx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .WS_POL(1'b0)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sck_i        (sck_i),
        .ws_i         (ws_i),
        .sd_i         (sd_i),
        .left_o       (left_o),
        .right_o      (right_o),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .overflow_o   (overflow_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    // Passive monitor, sampled mid-cycle: transfers, valid cycles, error pulses.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pair_valid_o) valid_hi_cnt++;
            if (pair_valid_o && !v_prev) valid_start_cyc = cyc;
            if (pair_valid_o && pair_ready_i) begin
                xfer_cnt++;
                last_l = left_o;
                last_r = right_o;
            end
            if (frame_err_o) ferr_cnt++;
        end
        v_prev = pair_valid_o && !rst_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic ws, input logic sd, input bit pulse);
        sck_i = 1'b0;
        ws_i  = ws;
        sd_i  = sd;
        repeat (4) tick();
        sck_i = 1'b1;
        rise_set_cyc = cyc;
        if (pulse) pair_ready_i = 1'b1;
        tick();
        if (pulse) pair_ready_i = 1'b0;
        repeat (3) tick();
    endtask

    // Slot indices first..last-1; index 0 is the I2S delay bit, 1..SW carry MSB..LSB.
    task automatic send_slot(input logic ws, input logic [SW-1:0] word,
                             input int first, input int last, input bit pulse);
        for (int j = first; j < last; j++) begin
            logic b;
            b = (j >= 1 && j <= SW) ? word[SW-j] : 1'b0;
            send_bit(ws, b, pulse && (j == SW));
            if (j == SW) mark_cyc = rise_set_cyc;
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit pulse);
        send_slot(1'b0, l, 0, SLOT, 1'b0);
        send_slot(1'b1, r, 0, SLOT, pulse);
    endtask

    task automatic snap();
        base_x = xfer_cnt;
        base_v = valid_hi_cnt;
        base_f = ferr_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_left", left_o, 0);
        check("rst_right", right_o, 0);
        check("rst_valid", pair_valid_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_ferr", frame_err_o, 0);
        rst_i = 1'b0;
        tick();

        // Basic pair, preceded by a lead-in right slot that must be ignored
        snap();
        send_slot(1'b1, 24'h123456, 0, SLOT, 1'b0);
        check("lead_in_no_pair", xfer_cnt - base_x, 0);
        send_frame(24'hA5A5A5, 24'h3C3C3C, 1'b0);
        check("basic_xfers", xfer_cnt - base_x, 1);
        check("basic_left", last_l, 24'hA5A5A5);
        check("basic_right", last_r, 24'h3C3C3C);
        check("basic_valid_cycles", valid_hi_cnt - base_v, 1);
        check("basic_latency", valid_start_cyc, mark_cyc + 1);
        check("basic_no_ferr", ferr_cnt - base_f, 0);

        // Accept and complete in the same cycle
        pair_ready_i = 1'b0;
        snap();
        send_frame(24'h0F1E2D, 24'hF0E1D2, 1'b0);
        check("hold_valid", pair_valid_o, 1);
        check("hold_left", left_o, 24'h0F1E2D);
        send_frame(24'h5A5A5A, 24'hC3C3C3, 1'b1);
        check("sim_xfers", xfer_cnt - base_x, 1);
        check("sim_old_left", last_l, 24'h0F1E2D);
        check("sim_old_right", last_r, 24'hF0E1D2);
        check("sim_valid", pair_valid_o, 1);
        check("sim_new_left", left_o, 24'h5A5A5A);
        check("sim_new_right", right_o, 24'hC3C3C3);
        check("sim_no_ovf", overflow_o, 0);
        pair_ready_i = 1'b1;
        tick();
        tick();
        check("sim_drain_xfers", xfer_cnt - base_x, 2);
        check("sim_drain_left", last_l, 24'h5A5A5A);
        check("sim_drain_valid", pair_valid_o, 0);

        // Short left slot (10 SCKs), then recovery on the next frame
        snap();
        send_slot(1'b0, 24'h777777, 0, 10, 1'b0);
        send_slot(1'b1, 24'h888888, 0, SLOT, 1'b0);
        check("short_ferr_pulse", ferr_cnt - base_f, 1);
        check("short_no_pair", xfer_cnt - base_x, 0);
        send_frame(24'h13579B, 24'h2468AC, 1'b0);
        check("short_recover_xfers", xfer_cnt - base_x, 1);
        check("short_recover_left", last_l, 24'h13579B);
        check("short_recover_right", last_r, 24'h2468AC);
        check("short_ferr_once", ferr_cnt - base_f, 1);

        // Reset pulsed at bit 12 of a left slot
        snap();
        send_slot(1'b0, 24'hDEADBE, 0, 13, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_left", left_o, 0);
        check("mrst_right", right_o, 0);
        check("mrst_valid", pair_valid_o, 0);
        check("mrst_ferr", frame_err_o, 0);
        send_slot(1'b0, 24'hDEADBE, 13, SLOT, 1'b0);
        send_slot(1'b1, 24'hBEEF01, 0, SLOT, 1'b0);
        check("mrst_no_pair", xfer_cnt - base_x, 0);
        send_frame(24'h654321, 24'hFEDCBA, 1'b0);
        check("mrst_xfers", xfer_cnt - base_x, 1);
        check("mrst_left_new", last_l, 24'h654321);
        check("mrst_right_new", last_r, 24'hFEDCBA);

        // Reset released during a right slot
        rst_i = 1'b1;
        send_slot(1'b0, 24'h111111, 0, SLOT, 1'b0);
        send_slot(1'b1, 24'h222222, 0, 10, 1'b0);
        check("mid_rst_left_zero", left_o, 0);
        rst_i = 1'b0;
        snap();
        send_slot(1'b1, 24'h222222, 10, SLOT, 1'b0);
        check("mid_no_pair", xfer_cnt - base_x, 0);
        check("mid_no_valid", valid_hi_cnt - base_v, 0);
        send_frame(24'hABCDEF, 24'h102030, 1'b0);
        check("mid_xfers", xfer_cnt - base_x, 1);
        check("mid_left", last_l, 24'hABCDEF);
        check("mid_right", last_r, 24'h102030);

        // Backpressure across two frames
        pair_ready_i = 1'b0;
        snap();
        send_frame(24'h314159, 24'h265358, 1'b0);
        check("bp_valid1", pair_valid_o, 1);
        check("bp_ovf1", overflow_o, 0);
        send_frame(24'h979323, 24'h846264, 1'b0);
        check("bp_valid2", pair_valid_o, 1);
        check("bp_hold_left", left_o, 24'h314159);
        check("bp_hold_right", right_o, 24'h265358);
        check("bp_ovf2", overflow_o, 1);
        check("bp_no_xfer", xfer_cnt - base_x, 0);
        pair_ready_i = 1'b1;
        tick();
        tick();
        check("bp_xfers", xfer_cnt - base_x, 1);
        check("bp_acc_left", last_l, 24'h314159);
        check("bp_acc_right", last_r, 24'h265358);
        check("bp_valid_drop", pair_valid_o, 0);
        check("bp_ovf_sticky", overflow_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24: captured bits per channel, MSB first, range 8..31.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: SCK periods per WS half-frame, matching the clock generator's SCKS_PER_FRAME.
REQ-003 SHALL have parameter WS_POL, default 1'b0: WS level that marks the left channel.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i input 1, system clock; all logic on rising edge.
REQ-005 SHALL have rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have sck_i, input, 1 bit: I2S bit clock, sampled as data at clk_i.
REQ-007 SHALL have ws_i, input, 1 bit: I2S word select.
REQ-008 SHALL have sd_i, input, 1 bit: serial data from the microphone/codec.
REQ-009 SHALL have left_o, output, SAMPLE_WIDTH bits: left sample of the held pair.
REQ-010 SHALL have right_o, output, SAMPLE_WIDTH bits: right sample of the held pair.
REQ-011 SHALL have pair_valid_o, output, 1 bit: stereo pair available.
REQ-012 SHALL have pair_ready_i, input, 1 bit: consumer accepts the pair.
REQ-013 SHALL have overflow_o, output, 1 bit: sticky; a completed pair was dropped.
REQ-014 SHALL have frame_err_o, output, 1 bit: one-cycle pulse; a slot was too short.

Function
REQ-015 SHALL detect SCK rising and falling edges by comparing sck with its registered previous value; rise = !prev & cur, fall = prev & !cur.
REQ-016 SHALL sample sd and ws on SCK rise only.
REQ-017 SHALL run an FSM with states IDLE, LEFT and RIGHT.
REQ-018 SHALL stay in IDLE after reset until a rise sees ws == WS_POL where the previous rise saw ~WS_POL, then go to LEFT; data before that is ignored.
REQ-019 SHALL, on any rise where ws differs from its previous sampled value, clear the bit counter; the FSM then enters LEFT if ws == WS_POL, else RIGHT.
REQ-020 SHALL treat the I2S one-bit delay as follows: rise index 0 of a slot is ignored, and indices 1..SAMPLE_WIDTH shift sd into the channel shift register MSB first; later indices are ignored.
REQ-021 SHALL, when the left slot captures bit SAMPLE_WIDTH, copy the shift register to the left holding register.
REQ-022 SHALL, when the right slot captures bit SAMPLE_WIDTH, complete the pair and drive left_o/right_o with pair_valid_o=1 on the next clk_i cycle.
REQ-023 SHALL use valid/ready: the pair is transferred in a cycle where pair_valid_o && pair_ready_i; pair_valid_o then drops unless a new pair completes in that same cycle, in which case the new pair loads and valid stays 1.
REQ-024 SHALL, when a pair completes while pair_valid_o=1 and pair_ready_i=0, drop the new pair, keep the held pair stable, and set overflow_o.
REQ-025 SHALL, if ws changes before bit SAMPLE_WIDTH of the current slot is captured, discard that slot, pulse frame_err_o for 1 cycle, and never emit the partial pair.
REQ-026 SHALL keep the bit counter at $clog2(SLOT_WIDTH+1) bits, saturating at SLOT_WIDTH with no wrap.

Reset
REQ-027 SHALL, on reset, set FSM=IDLE, counter=0, shift/holding registers=0, left_o=right_o=0, pair_valid_o=0, overflow_o=0, frame_err_o=0, and the previous-sck and previous-ws registers to 0 and WS_POL.
REQ-028 SHALL let reset asserted mid-slot abandon any partial sample; after reset the block re-enters via IDLE per REQ-018.

Configuration
REQ-029 SHALL, with I2S_RX_INPUT_SYNC_EN defined, pass sck_i, ws_i and sd_i through 2-flop synchronizers reset to 0/WS_POL/0, adding 2 clk_i cycles of latency to all responses.
REQ-030 SHALL, without I2S_RX_INPUT_SYNC_EN, use the inputs directly, for the same-clock-domain generator case.

Structure
REQ-031 SHALL put the FSM state enum (rx_state_e) and the default SAMPLE_WIDTH/SLOT_WIDTH constants in fpga_template_pkg.
REQ-032 SHALL use one sub-module, i2s_edge_detect, producing sck rise/fall pulses; the synchronizer is optional inside it.

Verification
REQ-033 SHALL cover the basic pair: generator at SCK_DIV=8, SLOT_WIDTH=32, with the left word 0xA5A5A5 and the right word 0x3C3C3C sent and ready held at 1 -> left_o=0xA5A5A5 and right_o=0x3C3C3C, and pair_valid_o high for 1 cycle, 1 cycle after the 24th right-data rise.
REQ-034 SHALL cover start mid-frame: reset released during a right slot -> no pair output until after the first full left+right frame.
REQ-035 SHALL cover backpressure: ready=0 across two frames -> the first pair stays on the outputs, overflow_o=1, and the second pair is never seen; ready=1 -> the first pair is accepted.
REQ-036 SHALL cover a simultaneous accept and complete: ready pulses in the cycle a new pair completes -> the old pair transfers, the new pair loads, and valid stays 1 with no overflow.
REQ-037 SHALL cover a short slot: WS toggled after 10 SCKs -> a frame_err_o pulse, no pair emitted, and normal capture resumes on the next frame.
REQ-038 SHALL cover mid-slot reset: rst_i pulsed at bit 12 of a left slot -> all outputs are 0 the cycle after, and the next emitted pair is fully captured post-reset.
